// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter family.
package axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first asserted request above `last`, wrapping.
module axis_rr_pick #(
  parameter int NUM_SI = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_SI-1:0] req,
  input  logic [ID_W-1:0]   last,
  output logic [ID_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = NUM_SI; i >= 1; i--) begin
      idx = ID_W'((int'(last) + i) % NUM_SI);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arb.sv
// N-input AXI-Stream round-robin arbiter, grant locked from first beat to tlast.
// Define AXIS_ARB_OUT_REG_EN to drive the master side from a 2-entry skid buffer.
module axis_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int NUM_SI = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = clog2_min1(NUM_SI)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_SI-1:0]        s_axis_tvalid,
  output logic [NUM_SI-1:0]        s_axis_tready,
  input  logic [NUM_SI*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SI-1:0]        s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic                     busy
);

  state_t          state_reg;
  logic [ID_W-1:0] grant_reg;
  logic [ID_W-1:0] last_grant_reg;
  logic            busy_reg;

  logic [ID_W-1:0] pick_idx;
  logic            pick_vld;

  logic              locked;
  logic [DATA_W-1:0] s_data [NUM_SI];
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic              up_last;
  logic              up_xfer;

  axis_rr_pick #(
    .NUM_SI (NUM_SI),
    .ID_W   (ID_W)
  ) u_pick (
    .req     (s_axis_tvalid),
    .last    (last_grant_reg),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign locked = (state_reg == LOCKED);

  for (genvar gi = 0; gi < NUM_SI; gi++) begin : g_slice
    assign s_data[gi]        = s_axis_tdata[gi*DATA_W +: DATA_W];
    assign s_axis_tready[gi] = locked && (grant_reg == ID_W'(gi)) && up_ready;
  end

  // Upstream view of the granted input, as seen by the master side.
  assign up_valid = locked && s_axis_tvalid[grant_reg];
  assign up_data  = s_data[grant_reg];
  assign up_last  = s_axis_tlast[grant_reg];
  assign up_xfer  = up_valid && up_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_SI - 1);
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_vld) begin
            grant_reg <= pick_idx;
            state_reg <= LOCKED;
            busy_reg  <= 1'b1;
          end
        end
        LOCKED: begin
          // Gaps on the granted input keep the lock; only a delivered tlast frees it.
          if (up_xfer && up_last) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

`ifdef AXIS_ARB_OUT_REG_EN
  localparam int PTR_W = clog2_min1(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  beat_t            mem_reg [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  beat_t            head;

  // Ready depends only on occupancy, so m_axis_tready never reaches s_axis_tready.
  assign up_ready = (count_reg != CNT_W'(SKID_DEPTH));
  assign push     = up_xfer;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign head     = mem_reg[rd_ptr_reg];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= {up_data, up_last, grant_reg};
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign m_axis_tvalid = (count_reg != '0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.last;
  assign m_axis_tid    = head.id;
`else
  assign up_ready      = m_axis_tready;
  assign m_axis_tvalid = up_valid;
  assign m_axis_tdata  = locked ? up_data : '0;
  assign m_axis_tlast  = locked ? up_last : 1'b0;
  assign m_axis_tid    = locked ? grant_reg : '0;
`endif

endmodule

// File: tb/tb_axis_rr_arb.sv
// Scoreboard bench for axis_rr_arb: per-input beat queues drive the slaves, expected beats are queued in grant order.
module tb_axis_rr_arb;

  localparam int NUM_SI = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;
`ifdef AXIS_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [7:0] data;
  } src_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     areset = 1'b1;
  logic                     m_ready = 1'b0;
  logic [NUM_SI-1:0]        s_valid = '0;
  logic [NUM_SI-1:0]        s_last = '0;
  logic [NUM_SI*DATA_W-1:0] s_data = '0;
  logic [NUM_SI-1:0]        s_ready;
  logic                     m_valid;
  logic [DATA_W-1:0]        m_data;
  logic                     m_last;
  logic [ID_W-1:0]          m_tid;
  logic                     busy;

  src_t src_q [NUM_SI][$];
  exp_t sb [$];
  int   obs_cyc [$];
  exp_t mon_exp;
  logic [NUM_SI-1:0] take = '0;
  logic [NUM_SI-1:0] bub_shown = '0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  axis_rr_arb #(
    .NUM_SI (NUM_SI),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tid    (m_tid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: retire accepted beats and shown bubbles, then present the next head.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_SI; i++) begin
      if (src_q[i].size() > 0 && (take[i] || bub_shown[i])) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        s_valid[i]           = src_q[i][0].vld;
        s_last[i]            = src_q[i][0].last;
        s_data[i*8 +: 8]     = src_q[i][0].data;
        bub_shown[i]         = !src_q[i][0].vld;
      end else begin
        s_valid[i]           = 1'b0;
        s_last[i]            = 1'b0;
        s_data[i*8 +: 8]     = 8'h00;
        bub_shown[i]         = 1'b0;
      end
    end
  end

  // Monitor: sampled half a cycle before the edge that completes each handshake.
  always @(negedge clk) begin
    if (areset) begin
      take = '0;
    end else begin
      take = s_valid & s_ready;
      if (m_valid && m_ready) begin
        obs_cyc.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got tid=%0d data=%02h last=%0d required none", m_tid, m_data, m_last);
        end else begin
          mon_exp = sb.pop_front();
          if (m_tid !== mon_exp.id || m_data !== mon_exp.data || m_last !== mon_exp.last) begin
            bad++;
            $display("FAIL beat got tid=%0d data=%02h last=%0d required tid=%0d data=%02h last=%0d",
                     m_tid, m_data, m_last, mon_exp.id, mon_exp.data, mon_exp.last);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    areset  = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (s_ready !== 4'b0000) begin bad++; $display("FAIL reset_s_ready got %b required 0000", s_ready); end
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL reset_m_valid got %b required 0", m_valid); end
    total++; if (m_data !== 8'h00)    begin bad++; $display("FAIL reset_m_data got %02h required 00", m_data); end
    total++; if (m_last !== 1'b0)     begin bad++; $display("FAIL reset_m_last got %b required 0", m_last); end
    total++; if (m_tid !== 2'd0)      begin bad++; $display("FAIL reset_m_tid got %0d required 0", m_tid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got %b required 0", busy); end
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic test_single_packet();
    bit ok;
    apply_reset();
    @(posedge clk);
    obs_cyc.delete();
    for (int b = 0; b < 6; b++) begin
      src_q[0].push_back('{vld: 1'b1, last: (b == 5), data: 8'h10 + 8'(b)});
      sb.push_back('{id: 2'd0, data: 8'h10 + 8'(b), last: (b == 5)});
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL arb_cycle got valid=%b busy=%b required 0 0", m_valid, busy);
    end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_locked got %b required 1", busy); end
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_tid !== 2'd0) begin
      bad++; $display("FAIL first_beat got valid=%b tid=%0d required 1 0", m_valid, m_tid);
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_single left=%0d required 0", sb.size()); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_release got %b required 0", busy); end
    total++;
    if (obs_cyc.size() != 6) begin
      bad++; $display("FAIL single_count got %0d required 6", obs_cyc.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total++;
        if (obs_cyc[j+1] - obs_cyc[j] != 1) begin
          bad++; $display("FAIL single_spacing beat=%0d got %0d required 1", j, obs_cyc[j+1] - obs_cyc[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ids [3] = '{0, 1, 3};
    apply_reset();
    @(posedge clk);
    obs_cyc.delete();
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        src_q[ids[p]].push_back('{vld: 1'b1, last: (b == 1), data: 8'h20 + 8'(16 * p + b)});
        sb.push_back('{id: 2'(ids[p]), data: 8'h20 + 8'(16 * p + b), last: (b == 1)});
      end
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_b2b left=%0d required 0", sb.size()); end
    total++;
    if (obs_cyc.size() != 6) begin
      bad++; $display("FAIL b2b_count got %0d required 6", obs_cyc.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total++;
        if (obs_cyc[j+1] - obs_cyc[j] != ((j % 2 == 1) ? 2 : 1)) begin
          bad++; $display("FAIL b2b_spacing beat=%0d got %0d required %0d",
                          j, obs_cyc[j+1] - obs_cyc[j], (j % 2 == 1) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      src_q[2].push_back('{vld: 1'b1, last: (b == 3), data: 8'h40 + 8'(b)});
      sb.push_back('{id: 2'd2, data: 8'h40 + 8'(b), last: (b == 3)});
    end
    for (int k = 0; k < 7; k++) begin
      #1 m_ready = pat[k];
      @(negedge clk);
      #1;
`ifndef AXIS_ARB_OUT_REG_EN
      if (busy) begin
        total++;
        if (s_ready[2] !== m_ready) begin
          bad++; $display("FAIL ready_follow cycle=%0d got %b required %b", k, s_ready[2], m_ready);
        end
      end
`endif
      if (m_valid && !m_ready && sb.size() > 0) begin
        total++;
        if (m_data !== sb[0].data) begin
          bad++; $display("FAIL stall_data cycle=%0d got %02h required %02h", k, m_data, sb[0].data);
        end
      end
      @(posedge clk);
    end
    #1 m_ready = 1'b1;
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_bp left=%0d required 0", sb.size()); end
  endtask

  task automatic test_gap_lock();
    bit ok;
    @(posedge clk);
    for (int b = 0; b < 7; b++) begin
      src_q[1].push_back((b >= 2 && b <= 4) ? '{vld: 1'b0, last: 1'b0, data: 8'h00}
                         : '{vld: 1'b1, last: (b == 6), data: 8'h60 + 8'((b > 4) ? b - 3 : b)});
    end
    for (int b = 0; b < 4; b++) sb.push_back('{id: 2'd1, data: 8'h60 + 8'(b), last: (b == 3)});
    src_q[0].push_back('{vld: 1'b0, last: 1'b0, data: 8'h00});
    src_q[0].push_back('{vld: 1'b0, last: 1'b0, data: 8'h00});
    src_q[0].push_back('{vld: 1'b1, last: 1'b1, data: 8'h70});
    sb.push_back('{id: 2'd0, data: 8'h70, last: 1'b1});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      #1;
      if (src_q[1].size() > 0) begin
        total++;
        if (s_ready[0] !== 1'b0) begin bad++; $display("FAIL gap_other_ready cycle=%0d got %b required 0", k, s_ready[0]); end
        if (s_valid[1] === 1'b0) begin
          total++;
          if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy cycle=%0d got %b required 1", k, busy); end
`ifndef AXIS_ARB_OUT_REG_EN
          total++;
          if (m_tid !== 2'd1) begin bad++; $display("FAIL gap_tid cycle=%0d got %0d required 1", k, m_tid); end
`endif
        end
      end
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_gap left=%0d required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    bit found;
    @(posedge clk);
    for (int b = 0; b < 5; b++) begin
      src_q[3].push_back('{vld: 1'b1, last: (b == 4), data: 8'h80 + 8'(b)});
    end
    sb.push_back('{id: 2'd3, data: 8'h80, last: 1'b0});
`ifndef AXIS_ARB_OUT_REG_EN
    sb.push_back('{id: 2'd3, data: 8'h81, last: 1'b0});
`endif
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      if (src_q[3].size() == 3) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_reach_beat3 got left=%0d required 3", src_q[3].size()); end
    areset = 1'b1;
    src_q[3].delete();
    @(posedge clk);
    @(negedge clk);
    total++; if (s_ready !== 4'b0000) begin bad++; $display("FAIL mid_s_ready got %b required 0000", s_ready); end
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL mid_m_valid got %b required 0", m_valid); end
    total++; if (m_data !== 8'h00)    begin bad++; $display("FAIL mid_m_data got %02h required 00", m_data); end
    total++; if (m_last !== 1'b0)     begin bad++; $display("FAIL mid_m_last got %b required 0", m_last); end
    total++; if (m_tid !== 2'd0)      begin bad++; $display("FAIL mid_m_tid got %0d required 0", m_tid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy got %b required 0", busy); end
    total++; if (sb.size() != 0)      begin bad++; $display("FAIL mid_delivered left=%0d required 0", sb.size()); end
    @(posedge clk);
    #1 areset = 1'b0;
    @(posedge clk);
    src_q[0].push_back('{vld: 1'b1, last: 1'b1, data: 8'h90});
    src_q[3].push_back('{vld: 1'b1, last: 1'b1, data: 8'hA0});
    sb.push_back('{id: 2'd0, data: 8'h90, last: 1'b1});
    sb.push_back('{id: 2'd3, data: 8'hA0, last: 1'b1});
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_after_reset left=%0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_gap_lock();
    test_reset_mid_packet();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_arb.md
Name: axis_rr_arb

Overview:
- Parametrised N-input AXI-Stream arbiter with round-robin fairness and packet-granular locking. It is the successor to the fixed 2-input, 8-bit arbiter.
- Merges NUM_SI slave streams onto one master stream. Each grant is held from first beat to tlast.
- Emits the source index on m_axis_tid so downstream logic can demux or tag packets.
- Sits between multiple stream producers and a shared downstream consumer in the AXI-Stream subsystem.

Parameters:
- NUM_SI, 4, number of slave inputs (2..16).
- DATA_W, 8, tdata width in bits per input.
- ID_W, $clog2(NUM_SI) (minimum 1), width of m_axis_tid.

Ports:
- aclk  input  1  clock, all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- s_axis_tvalid  input  NUM_SI  per-input valid; bit i belongs to input i.
- s_axis_tready  output  NUM_SI  per-input ready.
- s_axis_tdata  input  NUM_SI*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tlast  input  NUM_SI  per-input end of packet.
- m_axis_tvalid  output  1  master valid.
- m_axis_tready  input  1  master ready.
- m_axis_tdata  output  DATA_W  master data.
- m_axis_tlast  output  1  master end of packet.
- m_axis_tid  output  ID_W  index of the granted input.
- busy  output  1  high while a packet is locked.

Behaviour:
- Reset, sampled on the aclk edge:
  - state=IDLE, last_grant=NUM_SI-1, so input 0 has top priority after reset.
  - All s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, busy=0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is high, the round-robin pick selects the first asserted input searching upward from last_grant+1, wrapping modulo NUM_SI.
  - The pick is registered into grant and the FSM moves to LOCKED on the next edge. This costs one arbitration cycle per packet.
  - No valid inputs: remain in IDLE.
- LOCKED:
  - m_axis_tvalid/tdata/tlast mirror input[grant] combinationally; m_axis_tid=grant; busy=1.
  - s_axis_tready[grant]=m_axis_tready; every other s_axis_tready=0.
  - A beat transfers when s_axis_tvalid[grant] and m_axis_tready are both high.
  - On a transfer with tlast=1: last_grant<=grant and state<=IDLE.
- Simultaneous requests: only one input is granted. The others wait. After the packet completes, the next asserted input above the previous grant wins.
- Gaps: the granted input dropping tvalid mid-packet does not release the lock. The arbiter stays LOCKED until tlast transfers, regardless of other requesters.
- A single-beat packet (tlast on the first beat) is legal: LOCKED for exactly one transfer cycle, then IDLE.
- Master backpressure (m_axis_tready=0): m_axis_* must hold stable and s_axis_tready[grant]=0. No beat may be lost or duplicated.
- Reset mid-packet: abandon the packet immediately and return to reset values. The remainder of the packet is not forwarded.
- Throughput: back-to-back packets from any inputs incur exactly one idle cycle on m_axis between tlast and the next first beat.
- Non-granted input data and last are ignored (don't-care).

Optional Feature:
- Macro: AXIS_ARB_OUT_REG_EN.
- Defined: a 2-entry skid buffer is inserted on the master side.
  - m_axis_* are driven from registers, adding 1 cycle of latency.
  - Full throughput is preserved.
  - s_axis_tready[grant] is the skid buffer's registered ready, so no combinational path exists from m_axis_tready.
  - Lock release happens when tlast is accepted into the buffer, not when it leaves.
  - Reset empties the buffer.
- Undefined: the master side is combinational as described above, with zero latency.

Decomposition:
- Package axis_arb_pkg holds:
  - State enum (IDLE, LOCKED).
  - Helper function for clog2 with a floor of 1.
  - Constant SKID_DEPTH=2.
- Sub-module axis_rr_pick: purely combinational round-robin picker.
  - Inputs: req[NUM_SI], last[ID_W].
  - Outputs: gnt_idx[ID_W], gnt_vld.
  - Reused by future multi-output switches.
- The skid buffer is inlined inside an `ifdef block.

Test Plan:
- After reset, input 0 sends a 6-beat packet (data 0x10..0x15, tlast on beat 6) with m_axis_tready=1 -> m_axis shows the same 6 beats with tid=0. busy falls after beat 6. Arbitration cycle: 1 cycle.
- Inputs 0, 1 and 3 all hold 2-beat packets from the same cycle -> grant order is 0, 1, 3, each separated by exactly one idle cycle. No interleaving within a packet.
- Input 2 sends a 4-beat packet while m_axis_tready toggles 1,0,0,1,1,0,1 -> exactly 4 beats delivered in order with stable data while stalled. s_axis_tready[2] follows m_axis_tready.
- Input 1 deasserts tvalid for 3 cycles mid-packet while input 0 is requesting -> lock held, input 0 not granted until input 1's tlast transfers.
- Reset asserted on beat 3 of a 5-beat packet from input 3 -> the next cycle shows all outputs 0. After release, input 0 wins over a simultaneous input 3 request.
- With AXIS_ARB_OUT_REG_EN, repeat scenario 2 -> identical beat sequence shifted by 1 cycle and still full throughput.
